// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and the ZERO_REG index helper for reg_file.
//   DEFAULT_WIDTH - default register width in bits
//   DEFAULT_DEPTH - default register count
//   zero_reg()    - index of the hardwired-zero register for a given depth
package reg_file_pkg;
    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_DEPTH = 32;

    function automatic int zero_reg(input int depth);
        return depth - 1;
    endfunction
endpackage

// File: rtl/reg_file_en_reg.sv
// en_reg: WIDTH-bit storage register with load enable and async active-low clear.
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low clear
//   en      - load enable
//   d       - data to load
//   q       - stored value
module en_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] nxt;

    // Enable mux in front of a plain D flip-flop; no clock gating.
    always_comb nxt = en ? d : q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= nxt;
    end
endmodule

// File: rtl/reg_file.sv
// reg_file: 1-write / 2-read register file whose top index (ZERO_REG) is hardwired to 0.
//   clk       - clock, rising edge
//   reset_n   - asynchronous active-low reset, clears every register
//   wr_en     - write enable
//   wr_addr   - write index
//   wr_data   - write data
//   rd_addr_a - read port A index
//   rd_data_a - read port A data, combinational
//   rd_addr_b - read port B index
//   rd_data_b - read port B data, combinational
// Optional feature: define REG_FILE_BYPASS_EN to forward wr_data to a read
// port addressing the register being written in the same cycle.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b
);
    localparam int ZERO = zero_reg(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] regs;

    // Storage only for real registers; the zero register is a constant.
    for (genvar i = 0; i < ZERO; i++) begin : g_reg
        logic we;
        assign we = wr_en && (wr_addr == AW'(i));
        en_reg #(.WIDTH(WIDTH)) u_reg (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (we),
            .d       (wr_data),
            .q       (regs[i])
        );
    end
    assign regs[ZERO] = '0;

`ifdef REG_FILE_BYPASS_EN
    localparam logic [AW-1:0] ZERO_A = AW'(ZERO);
    logic fwd_ok;
    // Forwarding must stay quiet during reset and for the zero register.
    assign fwd_ok    = wr_en && reset_n && (wr_addr != ZERO_A);
    assign rd_data_a = (fwd_ok && rd_addr_a == wr_addr) ? wr_data : regs[rd_addr_a];
    assign rd_data_b = (fwd_ok && rd_addr_b == wr_addr) ? wr_data : regs[rd_addr_b];
`else
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized self-checking bench for reg_file against an array model.
`timescale 1ns/1ps
module tb_reg_file;
    localparam int W = 64;
    localparam int D = 32;
    localparam int Z = D - 1;
`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [4:0]    rd_addr_a = '0;
    logic [W-1:0]  rd_data_a;
    logic [4:0]    rd_addr_b = '0;
    logic [W-1:0]  rd_data_b;

    logic [W-1:0]  model [D];
    int            total = 0;
    int            passed = 0;

    reg_file dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // What a read port must show right now, from the current inputs and stored state.
    function automatic logic [W-1:0] expect_rd(input logic [4:0] a);
        if (!reset_n || a == Z) return '0;
        if (BYP && wr_en && wr_addr == a) return wr_data;
        return model[a];
    endfunction

    task automatic do_write(input logic en, input logic [4:0] a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en = en; wr_addr = a; wr_data = d;
        @(posedge clk);
        if (en && a != Z) model[a] = d;
        #1;
        wr_en = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < D; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(D - 1 - i);
            #0.1;
            check({tag, "_a"}, rd_data_a, expect_rd(rd_addr_a));
            check({tag, "_b"}, rd_data_b, expect_rd(rd_addr_b));
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) model[i] = '0;
        // Reset held while a write is presented: nothing may land or forward.
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hFF;
        rd_addr_a = 5'd3;
        #1 check("rst_fwd", rd_data_a, 64'h0);
        @(posedge clk); #1;
        for (int i = 0; i < D; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(i);
            #0.1;
            check("rst_a", rd_data_a, 64'h0);
            check("rst_b", rd_data_b, 64'h0);
        end
        @(negedge clk);
        wr_en = 1'b0; reset_n = 1'b1;
        rd_addr_a = 5'd3;
        #1 check("rst_idx3", rd_data_a, 64'h0);

        // First write after reset release, then read both ports.
        do_write(1'b1, 5'd5, 64'hDEADBEEF_00000001);
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        #1;
        check("wr5_a", rd_data_a, 64'hDEADBEEF_00000001);
        check("wr5_b", rd_data_b, 64'hDEADBEEF_00000001);
        rd_addr_a = 5'd6;
        #1 check("idx6", rd_data_a, 64'h0);

        // Zero register: write is dropped, never forwarded, others unchanged.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'(Z); wr_data = 64'h1234;
        rd_addr_a = 5'(Z); rd_addr_b = 5'(Z);
        #1;
        check("zero_pre_a", rd_data_a, 64'h0);
        check("zero_pre_b", rd_data_b, 64'h0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check_all("zero");

        // Hold: disabled writes for 4 cycles.
        for (int c = 0; c < 4; c++) do_write(1'b0, 5'd5, 64'hAAAA);
        rd_addr_a = 5'd5;
        #1 check("hold5", rd_data_a, 64'hDEADBEEF_00000001);

        // Same-cycle read and write of index 7.
        do_write(1'b1, 5'd7, 64'h11);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h22; rd_addr_a = 5'd7;
        #1 check("rw7_pre", rd_data_a, BYP ? 64'h22 : 64'h11);
        @(posedge clk); model[7] = 64'h22; #1;
        wr_en = 1'b0;
        check("rw7_post", rd_data_a, 64'h22);

        // Random traffic with frequent read/write collisions and zero-reg hits.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = ($urandom_range(0, 7) == 0) ? 5'(Z) : 5'($urandom);
            wr_data = {$urandom, $urandom};
            rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
            rd_addr_b = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
            #1;
            check("rnd_a", rd_data_a, expect_rd(rd_addr_a));
            check("rnd_b", rd_data_b, expect_rd(rd_addr_b));
            @(posedge clk);
            if (wr_en && wr_addr != Z) model[wr_addr] = wr_data;
        end

        // Fill every register with its index, then pulse reset between edges.
        for (int i = 0; i < D; i++) do_write(1'b1, 5'(i), W'(i));
        check_all("fill");
        @(negedge clk);
        #1 reset_n = 1'b0;
        for (int i = 0; i < D; i++) model[i] = '0;
        for (int i = 0; i < D; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(i);
            #0.1;
            check("async_a", rd_data_a, 64'h0);
            check("async_b", rd_data_b, 64'h0);
        end
        reset_n = 1'b1;
        do_write(1'b1, 5'd9, 64'h99);
        rd_addr_a = 5'd9; rd_addr_b = 5'd1;
        #1;
        check("post_a", rd_data_a, 64'h99);
        check("post_b", rd_data_b, 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
